// File: rtl/instr_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles little-endian
// 32-bit words into instruction memory and releases the core once the checksum verifies.
module instr_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_cpu_hold
);

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        asm_q, asm_d;
    logic [7:0]         sum_q, sum_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               xfer;
    logic [15:0]        len_full;

    // Ready depends only on registered state, so valid never feeds back into ready.
    assign o_byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
    assign o_busy       = o_byte_ready;
    assign o_done       = (state_q == S_DONE);
    assign o_error      = (state_q == S_ERR);
    assign o_cpu_hold   = (state_q != S_DONE);
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;

    assign xfer     = o_byte_ready && i_byte_valid;
    assign len_full = {i_byte, len_lo_q};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        len_lo_d = len_lo_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        // NOTE: blocking assignments here, so sum_d below already includes this byte.
        if (xfer) begin
            sum_d = sum_q + i_byte;
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d = S_LEN_LO;
                    cnt_d   = '0;
                    lane_d  = '0;
                    sum_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = i_byte;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        total_d = CNT_W'(len_full);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: asm_d[7:0]   = i_byte;
                        2'd1: asm_d[15:8]  = i_byte;
                        2'd2: asm_d[23:16] = i_byte;
                        2'd3: begin
                            we_d    = 1'b1;
                            addr_d  = cnt_q[ADDR_W-1:0];
                            wdata_d = {i_byte, asm_q};
                            cnt_d   = cnt_q + CNT_W'(1);
                            if ((cnt_q + CNT_W'(1)) == total_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (sum_d == 8'h00) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-size loader and a 4-word loader share one stimulus stream.
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_in;

    logic        rdy_a, we_a, busy_a, done_a, err_a, hold_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic        rdy_b, we_b, busy_b, done_b, err_b, hold_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    int checks   = 0;
    int failures = 0;

    logic [9:0]  wa_addr[$];
    logic [31:0] wa_data[$];
    logic [1:0]  wb_addr[$];
    logic [31:0] wb_data[$];

    // Status word {ready, we, busy, done, error, hold}.
    localparam logic [31:0] ST_RESET = 32'h01;
    localparam logic [31:0] ST_BUSY  = 32'h29;
    localparam logic [31:0] ST_DONE  = 32'h04;
    localparam logic [31:0] ST_ERR   = 32'h03;

    localparam logic [7:0]  F1 [7]    = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h97};
    localparam logic [7:0]  F3 [15]   = '{8'h03, 8'h00,
                                          8'h93, 8'h00, 8'h00, 8'h00,
                                          8'h13, 8'h01, 8'h10, 8'h00,
                                          8'h93, 8'h01, 8'hF0, 8'hFF,
                                          8'hC3};
    localparam logic [31:0] EXP3 [3]  = '{32'h00000093, 32'h00100113, 32'hFFF00193};

    instr_loader #(.ADDR_W(10)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(byte_valid), .i_byte(byte_in),
        .o_byte_ready(rdy_a), .o_imem_we(we_a), .o_imem_addr(addr_a), .o_imem_wdata(wdata_a),
        .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_cpu_hold(hold_a)
    );

    instr_loader #(.ADDR_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(byte_valid), .i_byte(byte_in),
        .o_byte_ready(rdy_b), .o_imem_we(we_b), .o_imem_addr(addr_b), .o_imem_wdata(wdata_b),
        .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_cpu_hold(hold_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write pulse lasts one cycle, so one falling-edge sample per pulse.
    always @(negedge clk) begin
        if (we_a) begin
            wa_addr.push_back(addr_a);
            wa_data.push_back(wdata_a);
        end
        if (we_b) begin
            wb_addr.push_back(addr_b);
            wb_data.push_back(wdata_b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] st_a();
        return {26'd0, rdy_a, we_a, busy_a, done_a, err_a, hold_a};
    endfunction

    function automatic logic [31:0] st_b();
        return {26'd0, rdy_b, we_b, busy_b, done_b, err_b, hold_b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_addr.delete(); wa_data.delete();
        wb_addr.delete(); wb_data.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Presents one byte and holds it until loader A has accepted it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        while (!rdy_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 20) chk("ready_timeout", 32'(rdy_a), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status_a", st_a(), ST_RESET);
        chk("reset_status_b", st_b(), ST_RESET);
        chk("reset_addr", 32'(addr_a), 32'd0);
        chk("reset_wdata", wdata_a, 32'd0);
        rst = 1'b0;

        // Single word, back-to-back bytes.
        clear_log();
        do_start();
        chk("start_status", st_a(), ST_BUSY);
        for (int i = 0; i < 6; i++) send_byte(F1[i]);
        chk("s1_we_latency", 32'(we_a), 32'd1);
        chk("s1_addr", 32'(addr_a), 32'd0);
        chk("s1_wdata", wdata_a, 32'h00500513);
        send_byte(F1[6]);
        chk("s1_status_a", st_a(), ST_DONE);
        chk("s1_status_b", st_b(), ST_DONE);
        chk("s1_writes", 32'(wa_addr.size()), 32'd1);

        // Three words with valid toggling every other cycle.
        clear_log();
        do_start();
        chk("s2_restart_status", st_a(), ST_BUSY);
        for (int i = 0; i < 15; i++) begin
            send_byte(F3[i]);
            idle_cycle();
        end
        chk("s2_writes", 32'(wa_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa_addr.size()) begin
                chk($sformatf("s2_addr%0d", i), 32'(wa_addr[i]), 32'(i));
                chk($sformatf("s2_data%0d", i), wa_data[i], EXP3[i]);
            end
        end
        chk("s2_status", st_a(), ST_DONE);

        // Length zero and length one past the maximum.
        clear_log();
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("len0_status_a", st_a(), ST_ERR);
        chk("len0_status_b", st_b(), ST_ERR);
        do_start();
        chk("err_restart_status", st_a(), ST_BUSY);
        send_byte(8'h01);
        send_byte(8'h04);
        chk("len1025_status_a", st_a(), ST_ERR);
        chk("len1025_status_b", st_b(), ST_ERR);
        chk("len_err_writes", 32'(wa_addr.size() + wb_addr.size()), 32'd0);

        // Bad checksum still writes the word, then a good frame recovers.
        clear_log();
        do_start();
        for (int i = 0; i < 6; i++) send_byte(F1[i]);
        send_byte(8'h98);
        chk("badcs_status", st_a(), ST_ERR);
        chk("badcs_writes", 32'(wa_addr.size()), 32'd1);
        if (wa_data.size() > 0) chk("badcs_wdata", wa_data[0], 32'h00500513);
        do_start();
        for (int i = 0; i < 7; i++) send_byte(F1[i]);
        chk("recover_status", st_a(), ST_DONE);

        // len=5 exceeds the 4-word loader only; then reset mid-frame.
        clear_log();
        do_start();
        send_byte(8'h05);
        send_byte(8'h00);
        chk("len5_status_b", st_b(), ST_ERR);
        chk("len5_status_a", st_a(), ST_BUSY);
        send_byte(8'h13);
        send_byte(8'h05);
        do_reset();
        chk("midrst_status_a", st_a(), ST_RESET);
        chk("midrst_status_b", st_b(), ST_RESET);
        chk("midrst_addr", 32'(addr_a), 32'd0);
        chk("midrst_wdata", wdata_a, 32'd0);
        chk("midrst_writes", 32'(wa_addr.size()), 32'd0);

        // i_start while busy must not restart the frame.
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        do_start();
        chk("busy_start_status", st_a(), ST_BUSY);
        for (int i = 3; i < 7; i++) send_byte(F1[i]);
        chk("busy_start_done", st_a(), ST_DONE);
        chk("busy_start_writes", 32'(wa_addr.size()), 32'd1);
        if (wa_data.size() > 0) chk("busy_start_wdata", wa_data[0], 32'h00500513);

        // Maximum size for the 4-word loader: addresses 0..3, no wrap.
        clear_log();
        do_start();
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h84);
        chk("max_writes_b", 32'(wb_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wb_addr.size()) begin
                chk($sformatf("max_addr%0d", i), 32'(wb_addr[i]), 32'(i));
                chk($sformatf("max_data%0d", i), wb_data[i],
                    {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
            end
        end
        chk("max_status_b", st_b(), ST_DONE);
        chk("max_status_a", st_a(), ST_DONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
